production_tally: RTL
=====================

Name: production_tally

Overview:
- Parametrised successor to the fixed dozen/cork counting logic in the bottling-line top level.
- Counts finished bottles into packs of PACK_SIZE.
- Accumulates completed packs in a DIGITS-wide BCD batch counter, with target detection and a selectable auto-clear or saturate mode.
- Tracks cork stock as a BCD down-counter with refill, low and empty alarms.
- Sits between mef_principal (event pulses) and display (BCD digits).

Parameters:
- PACK_SIZE, 12: bottles per pack (2..15).
- PACK_W, 4: width of pack_count.
- DIGITS, 2: BCD digits of the batch counter (1..4).
- BATCH_TARGET, 10: decimal pack count that completes a batch (1..10^DIGITS-1).
- AUTO_CLEAR, 1: 1 = batch counter returns to 0 on reaching target; 0 = saturate until clear_batch.
- CORK_DIGITS, 2: BCD digits of cork stock.
- CORK_REFILL, 99: decimal stock loaded on reset and refill.
- CORK_LOW, 5: decimal threshold for cork_low.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  line running; when low, bottle_done and cork_used are ignored.
- bottle_done  in  1  single-cycle pulse, one bottle finished (pre-debounced upstream).
- cork_used  in  1  single-cycle pulse, one cork consumed.
- cork_refill  in  1  single-cycle pulse, reload stock to CORK_REFILL.
- clear_batch  in  1  single-cycle pulse, zero the pack and batch counters.
- pack_count  out  PACK_W  bottles in the current pack, 0..PACK_SIZE-1.
- pack_done  out  1  one-cycle pulse when a pack completes.
- batch_bcd  out  4*DIGITS  BCD pack count; digit 0 in bits [3:0].
- batch_full  out  1  AUTO_CLEAR=1: one-cycle pulse; AUTO_CLEAR=0: level.
- bottle_dropped  out  1  one-cycle pulse, bottle ignored because batch saturated.
- cork_bcd  out  4*CORK_DIGITS  BCD cork stock.
- cork_low  out  1  stock <= CORK_LOW.
- cork_empty  out  1  stock == 0.

Behaviour:
- Reset values:
  - pack_count=0, batch_bcd=0.
  - pack_done, batch_full, bottle_dropped = 0.
  - cork_bcd=CORK_REFILL.
  - cork_low and cork_empty are derived from the reset stock.
- All updates occur on the rising clock edge.
- Pulse outputs are registered: they assert in the cycle after the edge that consumed the event.
- cork_low and cork_empty are combinational from the stock register.
- Bottle path, evaluated when enable=1 and bottle_done=1:
  - pack_count < PACK_SIZE-1: increment.
  - pack_count == PACK_SIZE-1: pack_count <= 0, pack_done pulses, batch increments.
- Batch increment:
  - BCD ripple: a digit at 9 goes to 0 and carries into the next digit.
  - If the new value equals BATCH_TARGET:
    - AUTO_CLEAR=1: batch_bcd <= 0 in the same edge, and batch_full pulses.
    - AUTO_CLEAR=0: batch_bcd holds the target, and batch_full goes high and stays high.
- Saturated state (AUTO_CLEAR=0, batch_full=1):
  - bottle_done is not counted; pack_count is frozen.
  - bottle_dropped pulses for each ignored bottle.
- Clear:
  - clear_batch zeroes pack_count and batch_bcd and drops batch_full.
  - It has priority over a simultaneous bottle_done; that bottle is lost and not reported as dropped.
  - clear_batch is honoured regardless of enable.
- Cork path:
  - cork_refill loads CORK_REFILL and is honoured regardless of enable.
  - Otherwise, enable=1 and cork_used=1 decrements in BCD (digit at 0 borrows, becomes 9).
  - At stock 0, cork_used is ignored; there is no wrap.
  - Refill has priority over a simultaneous cork_used.
- Bottle and cork paths are independent; simultaneous events on both are each fully processed.
- enable low freezes the counters but does not clear them.
- Reset asserted mid-operation clears state immediately. No pulse output is generated by reset release.
- Elaboration checks: BATCH_TARGET < 10^DIGITS, CORK_REFILL < 10^CORK_DIGITS, CORK_LOW < CORK_REFILL.

Decomposition:
- Shared package production_pkg:
  - BCD_W=4 constant.
  - Function converting an integer to packed BCD, used for BATCH_TARGET, CORK_REFILL and CORK_LOW.
  - Function comparing packed BCD values (<=).
- Sub-module bcd_digit, a single decade counter:
  - Inputs: inc, dec, load, clear; outputs: carry, borrow.
  - Asynchronous reset and parametrised reset value.
  - Instantiated DIGITS times for the batch counter and CORK_DIGITS times for the cork stock (generate loops).

Test Plan:
1. Default params, enable=1, 12 bottle_done pulses -> pack_count runs 1..11, then 0; pack_done pulses once; batch_bcd=8'h01.
2. Default params, 120 bottles -> 10th pack: batch_full one-cycle pulse, batch_bcd=8'h00; digits pass 09->10 correctly before that.
3. AUTO_CLEAR=0, 120 bottles then 3 more -> batch_bcd=8'h10, batch_full held high, 3 bottle_dropped pulses, pack_count=0; clear_batch -> batch_full=0, batch_bcd=0.
4. Cork: 94 cork_used -> cork_bcd=8'h05, cork_low=1; 5 more -> 8'h00, cork_empty=1; 1 more -> stays 8'h00; cork_refill together with cork_used -> 8'h99.
5. enable=0 with bottle_done and cork_used pulses -> no counter changes; clear_batch and cork_refill still take effect.
6. Reset asserted between clock edges mid-pack (pack_count=7, cork=8'h42) -> outputs go to reset values immediately with no clock; no pulses after release.

Source files
------------

// File: rtl/production_pkg.sv
// production_pkg: shared BCD helpers for the production tally block
package production_pkg;
  localparam int BCD_W = 4;
  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[BCD_W*i+:BCD_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  // valid packed BCD orders the same as plain binary
  function automatic logic bcd_le(logic [31:0] a, logic [31:0] b);
    return a <= b;
  endfunction
endpackage

// File: rtl/production_tally_bcd_digit.sv
// bcd_digit: one decade of a BCD up/down counter with load and clear
module bcd_digit
  import production_pkg::*;
#(
  parameter logic [BCD_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic             clear,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] q,
  output logic             carry,
  output logic             borrow
);
  logic [BCD_W-1:0] q_d, q_q;
  always_comb
    q_d = clear ? '0 :
          load  ? load_val :
          inc   ? (q_q == 4'd9 ? 4'd0 : q_q + 4'd1) :
          dec   ? (q_q == 4'd0 ? 4'd9 : q_q - 4'd1) : q_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) q_q <= RST_VAL;
    else q_q <= q_d;
  assign q = q_q;
  assign carry = inc && q_q == 4'd9;
  assign borrow = dec && q_q == 4'd0;
endmodule

// File: rtl/production_tally.sv
// production_tally: bottle pack/batch counting and BCD cork stock tracking
module production_tally
  import production_pkg::*;
#(
  parameter int PACK_SIZE    = 12,
  parameter int PACK_W       = 4,
  parameter int DIGITS       = 2,
  parameter int BATCH_TARGET = 10,
  parameter int AUTO_CLEAR   = 1,
  parameter int CORK_DIGITS  = 2,
  parameter int CORK_REFILL  = 99,
  parameter int CORK_LOW     = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         bottle_done,
  input  logic                         cork_used,
  input  logic                         cork_refill,
  input  logic                         clear_batch,
  output logic [PACK_W-1:0]            pack_count,
  output logic                         pack_done,
  output logic [BCD_W*DIGITS-1:0]      batch_bcd,
  output logic                         batch_full,
  output logic                         bottle_dropped,
  output logic [BCD_W*CORK_DIGITS-1:0] cork_bcd,
  output logic                         cork_low,
  output logic                         cork_empty
);
  localparam bit AC = AUTO_CLEAR != 0;
  localparam logic [31:0] TGT_M1 = to_bcd(BATCH_TARGET - 1);
  localparam logic [31:0] REFILL_BCD = to_bcd(CORK_REFILL);
  localparam logic [31:0] LOW_BCD = to_bcd(CORK_LOW);
  if (BATCH_TARGET < 1 || BATCH_TARGET >= 10 ** DIGITS) begin : g_bad_target
    $error("BATCH_TARGET out of range for DIGITS");
  end
  if (CORK_REFILL >= 10 ** CORK_DIGITS) begin : g_bad_refill
    $error("CORK_REFILL out of range for CORK_DIGITS");
  end
  if (CORK_LOW >= CORK_REFILL) begin : g_bad_low
    $error("CORK_LOW must be below CORK_REFILL");
  end
  logic [PACK_W-1:0] pack_d, pack_q;
  logic pack_done_d, pack_done_q, full_d, full_q, dropped_d, dropped_q;
  logic batch_inc, batch_clr, cork_dec;
  logic [DIGITS:0] b_inc;
  logic [DIGITS-1:0] b_brw;
  logic [CORK_DIGITS:0] c_dec;
  logic [CORK_DIGITS-1:0] c_car;
  // target is caught one step early so auto-clear can zero the digits in the same edge
  always_comb begin
    pack_d = pack_q;
    pack_done_d = 1'b0;
    dropped_d = 1'b0;
    full_d = AC ? 1'b0 : full_q;
    batch_inc = 1'b0;
    batch_clr = clear_batch;
    if (clear_batch) begin
      pack_d = '0;
      full_d = 1'b0;
    end else if (enable && bottle_done) begin
      if (!AC && full_q) dropped_d = 1'b1;
      else if (pack_q == PACK_W'(PACK_SIZE - 1)) begin
        pack_d = '0;
        pack_done_d = 1'b1;
        batch_inc = 1'b1;
        if (batch_bcd == TGT_M1[BCD_W*DIGITS-1:0]) begin
          full_d = 1'b1;
          batch_clr = AC;
        end
      end else pack_d = pack_q + 1'b1;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pack_q <= '0;
      pack_done_q <= 1'b0;
      full_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      pack_q <= pack_d;
      pack_done_q <= pack_done_d;
      full_q <= full_d;
      dropped_q <= dropped_d;
    end
  assign b_inc[0] = batch_inc;
  for (genvar i = 0; i < DIGITS; i++) begin : g_batch
    bcd_digit #(.RST_VAL(4'd0)) u_digit (
      .clock, .reset, .inc(b_inc[i]), .dec(1'b0), .load(1'b0), .clear(batch_clr),
      .load_val(4'd0), .q(batch_bcd[BCD_W*i+:BCD_W]), .carry(b_inc[i+1]), .borrow(b_brw[i])
    );
  end
  assign cork_dec = enable && cork_used && !cork_refill && !cork_empty;
  assign c_dec[0] = cork_dec;
  for (genvar i = 0; i < CORK_DIGITS; i++) begin : g_cork
    bcd_digit #(.RST_VAL(REFILL_BCD[BCD_W*i+:BCD_W])) u_digit (
      .clock, .reset, .inc(1'b0), .dec(c_dec[i]), .load(cork_refill), .clear(1'b0),
      .load_val(REFILL_BCD[BCD_W*i+:BCD_W]), .q(cork_bcd[BCD_W*i+:BCD_W]),
      .carry(c_car[i]), .borrow(c_dec[i+1])
    );
  end
  // neither counter may run off its top digit
  a_no_wrap: assert property (@(posedge clock) disable iff (reset)
    !b_inc[DIGITS] && b_brw == '0 && !c_dec[CORK_DIGITS] && c_car == '0);
  assign pack_count = pack_q;
  assign pack_done = pack_done_q;
  assign batch_full = full_q;
  assign bottle_dropped = dropped_q;
  assign cork_empty = cork_bcd == '0;
  assign cork_low = bcd_le(32'(cork_bcd), LOW_BCD);
endmodule
